// File: rtl/dec_ram_pingpong_ctrl_if.sv
// Decoder write port and output stream handshake for the hard-decision ping-pong controller.
interface dec_ram_pingpong_ctrl_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 8
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_last, out_ready,
    input  wr_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_last, out_ready,
    output wr_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/dec_ram_pingpong_ctrl.sv
// Two-bank ping-pong controller for the hard-decision RAM: decoder fills one bank
// while the other, already committed, is streamed out through a 2-entry skid FIFO.
module dec_ram_pingpong_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int CW_LEN     = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  dec_ram_pingpong_ctrl_if.slave bus,
  output logic [ADDR_WIDTH-1:0] ram_address  [0:1],
  output logic [DATA_WIDTH-1:0] ram_data_in  [0:1],
  output logic                  ram_we       [0:1],
  output logic                  ram_cs       [0:1],
  input  logic [DATA_WIDTH-1:0] ram_data_out [0:1],
  output logic [1:0]            bank_full,
  output logic                  wr_err
);

  localparam logic [ADDR_WIDTH:0]   CW_LEN_X  = (ADDR_WIDTH+1)'(CW_LEN);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CW_LEN - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_t;

  rd_state_t             state, state_nxt;
  logic [1:0]            full;
  logic                  wsel, rsel;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic                  rd_vld_p1, rd_last_p1;
  logic [DATA_WIDTH-1:0] fifo_data [0:1];
  logic                  fifo_last [0:1];
  logic                  fifo_wp, fifo_rp;
  logic [1:0]            fifo_cnt;

  logic                  wr_hs, wr_addr_ok, wr_en, pop;
  logic [2:0]            pend;
  logic                  rd_issue, rd_done;

  assign bus.wr_ready  = !full[wsel];
  assign wr_hs         = bus.wr_valid && bus.wr_ready;
  assign wr_addr_ok    = {1'b0, bus.wr_addr} < CW_LEN_X;
  assign wr_en         = wr_hs && wr_addr_ok;

  assign bus.out_valid = (fifo_cnt != 2'd0);
  assign bus.out_data  = bus.out_valid ? fifo_data[fifo_rp] : '0;
  assign bus.out_last  = bus.out_valid && fifo_last[fifo_rp];
  assign pop           = bus.out_valid && bus.out_ready;
  assign bank_full     = full;

  // Words already buffered or on their way, net of the beat leaving this cycle.
  assign pend = 3'(fifo_cnt) + 3'(rd_vld_p1) - 3'(pop);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (full[rsel]) state_nxt = ISSUE;
      ISSUE:   if (rd_issue && rd_cnt == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:   if (rd_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_issue = (state == ISSUE) && (pend < 3'd2);
    rd_done  = (state == DRAIN) && pop && fifo_last[fifo_rp];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full      <= '0;
      wsel      <= 1'b0;
      rsel      <= 1'b0;
      rd_cnt    <= '0;
      rd_vld_p1 <= 1'b0;
      fifo_wp   <= 1'b0;
      fifo_rp   <= 1'b0;
      fifo_cnt  <= 2'd0;
      wr_err    <= 1'b0;
    end else begin
      // A commit still happens on an out-of-range last write; only the RAM access is dropped.
      if (wr_hs && bus.wr_last) begin
        full[wsel] <= 1'b1;
        wsel       <= ~wsel;
      end
      if (rd_done) begin
        full[rsel] <= 1'b0;
        rsel       <= ~rsel;
      end
      if ((bus.wr_valid && !bus.wr_ready) || (wr_hs && !wr_addr_ok))
        wr_err <= 1'b1;

      if (state == IDLE)  rd_cnt <= '0;
      else if (rd_issue)  rd_cnt <= rd_cnt + 1'b1;

      rd_vld_p1 <= rd_issue;
      if (rd_vld_p1) fifo_wp <= ~fifo_wp;
      if (pop)       fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + 2'(rd_vld_p1) - 2'(pop);
    end
  end

  // p0 -> p1: read issued to the RAM; p1 -> FIFO: RAM data captured with its last tag.
  always_ff @(posedge clk) begin
    if (rd_issue) rd_last_p1 <= (rd_cnt == LAST_ADDR);
    if (rd_vld_p1) begin
      fifo_data[fifo_wp] <= ram_data_out[rsel];
      fifo_last[fifo_wp] <= rd_last_p1;
    end
  end

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      ram_address[b] = '0;
      ram_data_in[b] = '0;
      ram_we[b]      = 1'b0;
      ram_cs[b]      = 1'b0;
      if (wr_en && wsel == 1'(b)) begin
        ram_cs[b]      = 1'b1;
        ram_we[b]      = 1'b1;
        ram_address[b] = bus.wr_addr;
        ram_data_in[b] = bus.wr_data;
      end else if (rd_issue && rsel == 1'(b)) begin
        ram_cs[b]      = 1'b1;
        ram_address[b] = rd_cnt;
      end
    end
  end

endmodule

// File: tb/tb_dec_ram_pingpong_ctrl.sv
// Directed bench for dec_ram_pingpong_ctrl with a behavioural two-bank RAM.
module tb_dec_ram_pingpong_ctrl;
  localparam int DW  = 4;
  localparam int AW  = 8;
  localparam int CWL = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dec_ram_pingpong_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  logic [AW-1:0] ram_address [0:1];
  logic [DW-1:0] ram_data_in [0:1];
  logic          ram_we      [0:1];
  logic          ram_cs      [0:1];
  logic [DW-1:0] rdq         [0:1];
  logic [1:0]    bank_full;
  logic          wr_err;

  dec_ram_pingpong_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CW_LEN(CWL)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_we(ram_we),
    .ram_cs(ram_cs), .ram_data_out(rdq), .bank_full(bank_full), .wr_err(wr_err)
  );

  // RAM: synchronous write, read data one cycle after a cs=1/we=0 cycle
  logic [DW-1:0] mem [0:1][0:(1<<AW)-1];
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++)
      if (ram_cs[b]) begin
        if (ram_we[b]) mem[b][ram_address[b]] <= ram_data_in[b];
        else           rdq[b] <= mem[b][ram_address[b]];
      end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] bq_data [$];
  logic          bq_last [$];
  int            bq_cyc  [$];
  int            hold_cnt = 0, hold_bad = 0, nwr = 0, viol = 0, ovl = 0;
  logic          stall_q = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic          hold_last = 1'b0;
  logic          wrr_hist [0:1023];

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      bq_data.push_back(bus.out_data);
      bq_last.push_back(bus.out_last);
      bq_cyc.push_back(cyc);
    end
    if (stall_q) begin
      hold_cnt <= hold_cnt + 1;
      if (!(bus.out_valid && bus.out_data == hold_data && bus.out_last == hold_last))
        hold_bad <= hold_bad + 1;
    end
    stall_q   <= bus.out_valid && !bus.out_ready && !reset;
    hold_data <= bus.out_data;
    hold_last <= bus.out_last;
    wrr_hist[cyc % 1024] <= bus.wr_ready;
    nwr  <= nwr + int'(ram_cs[0] && ram_we[0]) + int'(ram_cs[1] && ram_we[1]);
    viol <= viol + int'(ram_cs[0] && ram_we[0] && bank_full[0])
                 + int'(ram_cs[1] && ram_we[1] && bank_full[1]);
    if (ram_cs[0] && !ram_we[0] && ram_cs[1] && ram_we[1]) ovl <= ovl + 1;
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_bus();
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_cw(input logic [DW-1:0] v0, v1, v2, v3, output int c_commit);
    logic [DW-1:0] v [0:3];
    v = '{v0, v1, v2, v3};
    c_commit = 0;
    for (int i = 0; i < CWL; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = AW'(i);
      bus.wr_data  = v[i];
      bus.wr_last  = (i == CWL - 1);
      if (i == CWL - 1) c_commit = cyc;
      tick();
    end
    idle_bus();
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (bq_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(bq_data.size()), 32'(n));
  endtask

  task automatic check_stream(input string tag, input int base, input logic [DW-1:0] e0, e1, e2, e3);
    logic [DW-1:0] e [0:3];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < CWL; i++)
      if (bq_data.size() > base + i) begin
        check({tag, "_data"}, 32'(bq_data[base+i]), 32'(e[i]));
        check({tag, "_last"}, 32'(bq_last[base+i]), 32'(i == CWL - 1));
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    int c, c2, base, L, nw0, ov0, h0, hb0;
    logic [31:0] pat;

    // reset state
    do_reset();
    check("rst_wr_ready",  32'(bus.wr_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data), 32'd0);
    check("rst_out_last",  32'(bus.out_last), 32'd0);
    check("rst_bank_full", 32'(bank_full), 32'd0);
    check("rst_wr_err",    32'(wr_err), 32'd0);
    check("rst_ram_ctl",   32'({ram_cs[0], ram_cs[1], ram_we[0], ram_we[1]}), 32'd0);
    check("rst_ram_addr",  32'({ram_address[0], ram_address[1]}), 32'd0);

    // single codeword 1,0,1,1
    bus.out_ready = 1'b1;
    base = bq_data.size();
    write_cw(4'd1, 4'd0, 4'd1, 4'd1, c);
    check("t1_full_set", 32'(bank_full), 32'b01);
    wait_beats(base + 4, 20, "t1_beats");
    check_stream("t1", base, 4'd1, 4'd0, 4'd1, 4'd1);
    if (bq_cyc.size() >= base + 4) begin
      check("t1_first_cyc", 32'(bq_cyc[base] - c), 32'd4);
      check("t1_last_cyc",  32'(bq_cyc[base+3] - c), 32'd7);
    end
    check("t1_full_clr", 32'(bank_full), 32'b00);
    check("t1_wr_ready", 32'(bus.wr_ready), 32'd1);

    // ping-pong: B written into bank 1 while A drains from bank 0
    do_reset();
    bus.out_ready = 1'b1;
    base = bq_data.size();
    ov0 = ovl;
    write_cw(4'd3, 4'd5, 4'd7, 4'd9, c);
    write_cw(4'd2, 4'd4, 4'd6, 4'd8, c2);
    wait_beats(base + 8, 40, "t2_beats");
    check_stream("t2a", base, 4'd3, 4'd5, 4'd7, 4'd9);
    check_stream("t2b", base + 4, 4'd2, 4'd4, 4'd6, 4'd8);
    check("t2_overlap", 32'(ovl > ov0), 32'd1);

    // overflow: both banks full with the stream stalled
    do_reset();
    base = bq_data.size();
    write_cw(4'd1, 4'd2, 4'd3, 4'd4, c);
    write_cw(4'd5, 4'd6, 4'd7, 4'd8, c2);
    tick();
    check("t3_wr_ready_lo", 32'(bus.wr_ready), 32'd0);
    check("t3_both_full",   32'(bank_full), 32'b11);
    check("t3_err_before",  32'(wr_err), 32'd0);
    nw0 = nwr;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = '0;
    bus.wr_data  = 4'hF;
    tick();
    idle_bus();
    check("t3_err_set", 32'(wr_err), 32'd1);
    check("t3_no_write", 32'(nwr - nw0), 32'd0);
    bus.out_ready = 1'b1;
    wait_beats(base + 4, 20, "t3_a_beats");
    repeat (3) tick();
    if (bq_cyc.size() >= base + 4) begin
      L = bq_cyc[base+3];
      check("t3_ready_at_L",  32'(wrr_hist[L % 1024]), 32'd0);
      check("t3_ready_at_L1", 32'(wrr_hist[(L + 1) % 1024]), 32'd1);
    end
    wait_beats(base + 8, 40, "t3_b_beats");
    check_stream("t3a", base, 4'd1, 4'd2, 4'd3, 4'd4);
    check_stream("t3b", base + 4, 4'd5, 4'd6, 4'd7, 4'd8);

    // backpressure: fixed irregular out_ready pattern during the drain
    do_reset();
    base = bq_data.size();
    h0 = hold_cnt;
    hb0 = hold_bad;
    pat = 32'hB5A4_D2C8;
    write_cw(4'd0, 4'd1, 4'd2, 4'd3, c);
    for (int i = 0; i < 32 && bq_data.size() < base + 4; i++) begin
      bus.out_ready = pat[i];
      tick();
    end
    bus.out_ready = 1'b1;
    repeat (6) tick();
    check("t4_count", 32'(bq_data.size() - base), 32'd4);
    check_stream("t4", base, 4'd0, 4'd1, 4'd2, 4'd3);
    check("t4_stalls_seen", 32'(hold_cnt > h0), 32'd1);
    check("t4_hold_stable", 32'(hold_bad - hb0), 32'd0);

    // address error and commit of an out-of-range last write
    do_reset();
    bus.out_ready = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 8'd2;
    bus.wr_data  = 4'd5;
    @(negedge clk);
    check("t5_ok_ctl",  32'({ram_cs[0], ram_we[0], ram_cs[1], ram_we[1]}), 32'b1100);
    check("t5_ok_addr", 32'(ram_address[0]), 32'd2);
    check("t5_ok_data", 32'(ram_data_in[0]), 32'd5);
    tick();
    bus.wr_addr = AW'(CWL);
    bus.wr_data = 4'd9;
    @(negedge clk);
    check("t5_bad_ctl", 32'({ram_cs[0], ram_we[0], ram_cs[1], ram_we[1]}), 32'd0);
    tick();
    idle_bus();
    check("t5_err", 32'(wr_err), 32'd1);
    check("t5_no_commit", 32'(bank_full), 32'b00);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 8'd5;
    bus.wr_last  = 1'b1;
    tick();
    idle_bus();
    check("t5_commit", 32'(bank_full), 32'b01);
    check("t5_err_sticky", 32'(wr_err), 32'd1);

    // reset in the middle of a drain
    do_reset();
    bus.out_ready = 1'b1;
    base = bq_data.size();
    write_cw(4'd5, 4'd6, 4'd7, 4'd8, c);
    wait_beats(base + 2, 20, "t6_partial");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_bank_full", 32'(bank_full), 32'b00);
    check("t6_wr_ready",  32'(bus.wr_ready), 32'd1);
    base = bq_data.size();
    write_cw(4'd9, 4'd10, 4'd11, 4'd12, c);
    wait_beats(base + 4, 20, "t6_beats");
    repeat (4) tick();
    check("t6_count", 32'(bq_data.size() - base), 32'd4);
    check_stream("t6", base, 4'd9, 4'd10, 4'd11, 4'd12);

    check("port_share", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
